// File: rtl/delta_sched_pkg.sv
// delta_sched_pkg
// Shared types and constants for the delta-period scheduler:
//   state_e       - scheduler FSM states (IDLE, RUN)
//   DEF_NUM_REQ   - default number of requesters
//   DEF_REP_W     - default repetition-count width
//   sat_len()     - effective period length, max(len, 1)
package delta_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_REP_W   = 8;

  // A zero-length period is meaningless for the counter, so it is run as one cycle.
  function automatic logic [31:0] sat_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/delta_rr_arbiter.sv
// delta_rr_arbiter
// Combinational round-robin arbiter. The search starts one position after
// the previous winner and wraps, so every requester is served in turn.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  IDX_W    index of the previous winner
//   winner     out NUM_REQ  one-hot winner, zero when no request is present
module delta_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] winner
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] sel;
    // NOTE: every combinational output gets a default before any condition so no latch is inferred.
    winner = '0;
    found  = 1'b0;
    sel    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sel = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req[sel]) begin
        winner[sel] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delta_sched.sv
// delta_sched
// Round-robin scheduler sharing one delta-simulation period counter among
// NUM_REQ requesters. The granted owner gets reps periods of L = max(len,1)
// cycles each; tick marks the last cycle of every period, last_tick/done the
// last cycle of the run. Dropping req mid-run aborts the run.
// Ports:
//   clock      in  1               rising-edge clock
//   reset      in  1               asynchronous reset, active low
//   req        in  NUM_REQ         request levels
//   req_len    in  NUM_REQ*LEN_W   period length per requester
//   req_reps   in  NUM_REQ*REP_W   period count per requester
//   grant      out NUM_REQ         registered one-hot owner
//   tick       out 1               last cycle of each period
//   last_tick  out 1               last cycle of the final period
//   done       out NUM_REQ         completion pulse to the owner
//   aborted    out 1               owner dropped req during RUN
//   busy       out 1               registered, high in RUN

// Normally supplied by sys_defs.svh; fallback keeps the block standalone.
`ifndef DELTA_SIM_LEN
`define DELTA_SIM_LEN 8
`endif

module delta_sched
  import delta_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int LEN_W   = `DELTA_SIM_LEN,
  parameter int REP_W   = DEF_REP_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*REP_W-1:0] req_reps,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     tick,
  output logic                     last_tick,
  output logic [NUM_REQ-1:0]       done,
  output logic                     aborted,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic [LEN_W-1:0]   pc_q, pc_d;
  logic [REP_W-1:0]   rc_q, rc_d;

  logic [NUM_REQ-1:0] winner;
  logic [IDX_W-1:0]   win_idx;
  logic [LEN_W-1:0]   win_len;
  logic [REP_W-1:0]   win_reps;
  logic               owner_req;
  logic               period_end;
  logic               run_last;

  delta_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = IDX_W'(i);
    end
  end

  assign win_len  = LEN_W'(sat_len(32'(req_len[win_idx*LEN_W +: LEN_W])));
  assign win_reps = req_reps[win_idx*REP_W +: REP_W];

  // last_grant_q doubles as the owner index while in RUN.
  assign owner_req  = req[last_grant_q];
  assign period_end = (pc_q == '0);
  assign run_last   = period_end && (rc_q == reps_q - REP_W'(1));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      busy_q       <= 1'b0;
      len_q        <= '0;
      reps_q       <= '0;
      pc_q         <= '0;
      rc_q         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      len_q        <= len_d;
      reps_q       <= reps_d;
      pc_q         <= pc_d;
      rc_q         <= rc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    len_d        = len_q;
    reps_d       = reps_q;
    pc_d         = pc_q;
    rc_d         = rc_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          last_grant_d = win_idx;
          // A zero-repetition request completes in the arbitration cycle.
          if (win_reps != '0) begin
            state_d = RUN;
            grant_d = winner;
            busy_d  = 1'b1;
            len_d   = win_len;
            reps_d  = win_reps;
            pc_d    = win_len - LEN_W'(1);
            rc_d    = '0;
          end
        end
      end
      RUN: begin
        if (!owner_req || run_last) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          pc_d    = '0;
          rc_d    = '0;
        end else if (period_end) begin
          pc_d = len_q - LEN_W'(1);
          rc_d = rc_q + REP_W'(1);
        end else begin
          pc_d = pc_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    tick      = 1'b0;
    last_tick = 1'b0;
    done      = '0;
    aborted   = 1'b0;
    if (state_q == RUN) begin
      // Abort wins over a coinciding period end.
      if (!owner_req) begin
        aborted = 1'b1;
      end else if (period_end) begin
        tick = 1'b1;
        if (run_last) begin
          last_tick = 1'b1;
          done      = grant_q;
        end
      end
    end else if (reset && (|req) && (win_reps == '0)) begin
      done = winner;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_delta_sched.sv
module tb_delta_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_len = '0;
  logic [31:0] req_reps = '0;
  logic [3:0]  grant;
  logic        tick;
  logic        last_tick;
  logic [3:0]  done;
  logic        aborted;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [11:0] obs;
  logic [11:0] exp_v;

  delta_sched #(
    .NUM_REQ (4),
    .LEN_W   (8),
    .REP_W   (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_len   (req_len),
    .req_reps  (req_reps),
    .grant     (grant),
    .tick      (tick),
    .last_tick (last_tick),
    .done      (done),
    .aborted   (aborted),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Observed bundle: {grant, busy, tick, last_tick, done, aborted}
  assign obs = {grant, busy, tick, last_tick, done, aborted};

  function automatic logic [11:0] ev(input logic [3:0] g, input logic t, input logic lt,
                                     input logic [3:0] d, input logic ab);
    return {g, |g, t, lt, d, ab};
  endfunction

  task automatic set_req(input int i, input int len, input int reps, input logic on);
    req_len[i*8 +: 8]  = 8'(len);
    req_reps[i*8 +: 8] = 8'(reps);
    req[i]             = on;
  endtask

  task automatic do_reset();
    req   = '0;
    reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    total_cnt++;
    if (obs !== 12'b0) $display("FAIL reset_async got %b exp %b", obs, 12'b0);
    else pass_cnt++;
    @(negedge clock);
    @(negedge clock);
    total_cnt++;
    if (obs !== 12'b0) $display("FAIL reset_hold got %b exp %b", obs, 12'b0);
    else pass_cnt++;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // req0, len=3, reps=2
  task automatic test_single();
    for (int c = 0; c <= 7; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) set_req(0, 3, 2, 1'b1);
      if (c == 7) req = '0;
      @(negedge clock);
      exp_v = ev((c >= 1 && c <= 6) ? 4'b0001 : 4'b0000, (c == 3 || c == 6), (c == 6),
                 (c == 6) ? 4'b0001 : 4'b0000, 1'b0);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL single c=%0d got %b exp %b", c, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  // All four held, len=1, reps=1: owners 0,1,2,3,0 on odd cycles.
  task automatic test_fairness();
    logic [3:0] g;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) for (int i = 0; i < 4; i++) set_req(i, 1, 1, 1'b1);
      if (c == 10) req = '0;
      @(negedge clock);
      g = ((c % 2) == 1) ? (4'b0001 << (((c - 1) / 2) % 4)) : 4'b0000;
      exp_v = ev(g, |g, |g, g, 1'b0);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL fairness c=%0d got %b exp %b", c, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  // len=0 runs as a one-cycle period.
  task automatic test_len_zero();
    do_reset();
    for (int c = 0; c <= 2; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) set_req(0, 0, 1, 1'b1);
      if (c == 2) req = '0;
      @(negedge clock);
      exp_v = (c == 1) ? ev(4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0) : 12'b0;
      total_cnt++;
      if (obs !== exp_v) $display("FAIL len_zero c=%0d got %b exp %b", c, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  // reps=0 on req1: done in the arbitration cycle, no grant, last_grant moves to 1,
  // so the following 0/1 contest is won by 0.
  task automatic test_reps_zero();
    for (int c = 0; c <= 3; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) set_req(1, 3, 0, 1'b1);
      if (c == 1) begin
        set_req(1, 1, 1, 1'b1);
        set_req(0, 1, 1, 1'b1);
      end
      if (c == 3) req = '0;
      @(negedge clock);
      case (c)
        0:       exp_v = ev(4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0);
        2:       exp_v = ev(4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0);
        default: exp_v = 12'b0;
      endcase
      total_cnt++;
      if (obs !== exp_v) $display("FAIL reps_zero c=%0d got %b exp %b", c, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    // req2, len=5, reps=4, dropped at cycle 7
    for (int c = 0; c <= 8; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) set_req(2, 5, 4, 1'b1);
      if (c == 7) req[2] = 1'b0;
      @(negedge clock);
      exp_v = ev((c >= 1 && c <= 7) ? 4'b0100 : 4'b0000, (c == 5), 1'b0, 4'b0000, (c == 7));
      total_cnt++;
      if (obs !== exp_v) $display("FAIL abort c=%0d got %b exp %b", c, obs, exp_v);
      else pass_cnt++;
    end
    // req3, len=1, reps=3, dropped on a cycle where pc==0: abort suppresses tick
    for (int c = 0; c <= 3; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) set_req(3, 1, 3, 1'b1);
      if (c == 2) req[3] = 1'b0;
      @(negedge clock);
      case (c)
        1:       exp_v = ev(4'b1000, 1'b1, 1'b0, 4'b0000, 1'b0);
        2:       exp_v = ev(4'b1000, 1'b0, 1'b0, 4'b0000, 1'b1);
        default: exp_v = 12'b0;
      endcase
      total_cnt++;
      if (obs !== exp_v) $display("FAIL abort_pc0 c=%0d got %b exp %b", c, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  // Reset at cycle 4 of a len=4, reps=3 run; afterwards requester 0 wins first.
  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) set_req(0, 4, 3, 1'b1);
      @(negedge clock);
    end
    total_cnt++;
    if (obs !== ev(4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0))
      $display("FAIL areset_pre got %b exp %b", obs, ev(4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0));
    else pass_cnt++;
    @(posedge clock);
    #1;
    total_cnt++;
    if (obs !== ev(4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0))
      $display("FAIL areset_tick got %b exp %b", obs, ev(4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0));
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (obs !== 12'b0) $display("FAIL areset_immediate got %b exp %b", obs, 12'b0);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (obs !== 12'b0) $display("FAIL areset_hold got %b exp %b", obs, 12'b0);
    else pass_cnt++;
    for (int c = 0; c <= 3; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) begin
        reset = 1'b1;
        set_req(0, 2, 1, 1'b1);
        set_req(1, 2, 1, 1'b1);
      end
      if (c == 3) req = '0;
      @(negedge clock);
      exp_v = ev((c == 1 || c == 2) ? 4'b0001 : 4'b0000, (c == 2), (c == 2),
                 (c == 2) ? 4'b0001 : 4'b0000, 1'b0);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL areset_after c=%0d got %b exp %b", c, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_len_zero();
    test_reps_zero();
    test_abort();
    test_async_reset();
    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
